// File: rtl/scontrol_cmd_tx.sv
// Host-side transmitter for the 3-bit strobed command bus of the power-stage controller.
// Commands are queued in a small FIFO and sent one strobe frame each, or as the 7,0,7,0,code unlock macro.
module scontrol_cmd_tx #(
   parameter int SETUP_CYCLES = 2,
   parameter int HIGH_CYCLES  = 50,
   parameter int LOW_CYCLES   = 50,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_code,
   input  logic       cmd_macro,
   output logic [2:0] o_c,
   output logic       o_clk,
   output logic       busy,
   output logic       frame_done,
   output logic       seq_done
);

   localparam int MAX_CYCLES = (SETUP_CYCLES > HIGH_CYCLES) ?
                               ((SETUP_CYCLES > LOW_CYCLES) ? SETUP_CYCLES : LOW_CYCLES) :
                               ((HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES);
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] HIGH_LOAD  = CW'(HIGH_CYCLES - 1);
   localparam logic [CW-1:0] LOW_LOAD   = CW'(LOW_CYCLES - 1);
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [2:0]    LAST_STEP  = 3'd4;

   typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

   // Steps 0..3 are the unlock prefix; step 4 always carries the entry's own code.
   function automatic logic [2:0] step_code(input logic [2:0] step, input logic [2:0] code);
      case (step)
         3'd0, 3'd2: step_code = 3'd7;
         3'd1, 3'd3: step_code = 3'd0;
         default:    step_code = code;
      endcase
   endfunction

   logic [3:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          fifo_empty, fifo_full, push, pop;
   logic [3:0]    head;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    step_reg, step_next;
   logic [2:0]    code_reg, code_next;
   logic [2:0]    oc_reg, oc_next;
   logic          oclk_reg;
   logic [2:0]    first_step;

   assign fifo_full  = (count_reg == FULL_COUNT);
   assign fifo_empty = (count_reg == '0);
   assign cmd_ready  = !fifo_full;
   assign push       = cmd_valid && !fifo_full;
   assign head       = fifo_mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= {cmd_macro, cmd_code};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      step_next  = step_reg;
      code_next  = code_reg;
      oc_next    = oc_reg;
      pop        = 1'b0;
      first_step = head[3] ? 3'd0 : LAST_STEP;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               code_next  = head[2:0];
               step_next  = first_step;
               oc_next    = step_code(first_step, head[2:0]);
               cnt_next   = SETUP_LOAD;
               state_next = SETUP;
            end
         end
         SETUP: begin
            if (cnt_reg == '0) begin
               cnt_next   = HIGH_LOAD;
               state_next = HIGH;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         HIGH: begin
            if (cnt_reg == '0) begin
               cnt_next   = LOW_LOAD;
               state_next = LOW;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         LOW: begin
            if (cnt_reg == '0) begin
               if (step_reg == LAST_STEP) begin
                  state_next = IDLE;
               end else begin
                  // Next macro frame follows immediately, with no idle gap.
                  step_next  = step_reg + 1'b1;
                  oc_next    = step_code(step_reg + 1'b1, code_reg);
                  cnt_next   = SETUP_LOAD;
                  state_next = SETUP;
               end
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         step_reg  <= '0;
         code_reg  <= '0;
         oc_reg    <= '0;
         oclk_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         step_reg  <= step_next;
         code_reg  <= code_next;
         oc_reg    <= oc_next;
         oclk_reg  <= (state_next == HIGH);
      end
   end

   assign o_c        = oc_reg;
   assign o_clk      = oclk_reg;
   assign busy       = (state_reg != IDLE) || !fifo_empty;
   assign frame_done = (state_reg == LOW) && (cnt_reg == '0);
   assign seq_done   = frame_done && (step_reg == LAST_STEP);

endmodule

// File: tb/tb_scontrol_cmd_tx.sv
// Bench for scontrol_cmd_tx: one instance at default timing, one at 1/1/1 timing,
// table-driven frame checks plus a per-cycle reference model under random traffic.
`timescale 1ns/1ps
module tb_scontrol_cmd_tx;

   localparam int S0 = 2, H0 = 50, L0 = 50;
   localparam int S1 = 1, H1 = 1, L1 = 1;

   logic clk = 1'b0;
   logic [1:0]      rst_s, valid, macro, ready, oclk, busy, fd, sd;
   logic [1:0][2:0] code, oc;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;
   int sp[2], hp[2], lp[2];

   // Reference model state: queue of {macro,code}, current entry's frame code list and elapsed cycles
   bit         m_act[2];
   int         m_t[2], m_nf[2], m_qn[2];
   logic [3:0] m_q[2][4];
   logic [2:0] m_codes[2][5];
   logic [2:0] m_oc[2];

   typedef struct {
      int          inst;
      int          nent;
      logic [17:0] codes;
      logic [5:0]  macros;
      int          totfr;
      logic [29:0] exp_oc;
      logic        rdy_after;
   } vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   scontrol_cmd_tx #(.SETUP_CYCLES(S0), .HIGH_CYCLES(H0), .LOW_CYCLES(L0), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst(rst_s[0]), .cmd_valid(valid[0]), .cmd_ready(ready[0]),
      .cmd_code(code[0]), .cmd_macro(macro[0]), .o_c(oc[0]), .o_clk(oclk[0]),
      .busy(busy[0]), .frame_done(fd[0]), .seq_done(sd[0]));

   scontrol_cmd_tx #(.SETUP_CYCLES(S1), .HIGH_CYCLES(H1), .LOW_CYCLES(L1), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .rst(rst_s[1]), .cmd_valid(valid[1]), .cmd_ready(ready[1]),
      .cmd_code(code[1]), .cmd_macro(macro[1]), .o_c(oc[1]), .o_clk(oclk[1]),
      .busy(busy[1]), .frame_done(fd[1]), .seq_done(sd[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic model_cmp(input int i);
      int p, ph, f;
      logic e_clk, e_fd, e_sd;
      p     = sp[i] + hp[i] + lp[i];
      ph    = m_t[i] % p;
      f     = m_t[i] / p;
      e_clk = m_act[i] && (ph >= sp[i]) && (ph < sp[i] + hp[i]);
      e_fd  = m_act[i] && (ph == p - 1);
      e_sd  = e_fd && (f == m_nf[i] - 1);
      chk($sformatf("dut%0d o_c", i), 32'(oc[i]), 32'(m_oc[i]));
      chk($sformatf("dut%0d o_clk", i), 32'(oclk[i]), 32'(e_clk));
      chk($sformatf("dut%0d frame_done", i), 32'(fd[i]), 32'(e_fd));
      chk($sformatf("dut%0d seq_done", i), 32'(sd[i]), 32'(e_sd));
      chk($sformatf("dut%0d busy", i), 32'(busy[i]), 32'(m_act[i] || (m_qn[i] > 0)));
      chk($sformatf("dut%0d cmd_ready", i), 32'(ready[i]), 32'(m_qn[i] < 4));
   endtask

   task automatic model_edge(input int i, input logic r, input logic v, input logic [2:0] c, input logic m);
      int p;
      bit do_push;
      logic [3:0] hd;
      if (r) begin
         m_act[i] = 1'b0;
         m_qn[i]  = 0;
         m_t[i]   = 0;
         m_oc[i]  = 3'd0;
      end else begin
         p       = sp[i] + hp[i] + lp[i];
         do_push = v && (m_qn[i] < 4);
         if (m_act[i]) begin
            if (m_t[i] == m_nf[i] * p - 1) begin
               m_act[i] = 1'b0;
            end else begin
               m_t[i]++;
               if (m_t[i] % p == 0)
                  m_oc[i] = m_codes[i][m_t[i] / p];
            end
         end else if (m_qn[i] > 0) begin
            hd = m_q[i][0];
            for (int k = 0; k < 3; k++)
               m_q[i][k] = m_q[i][k + 1];
            m_qn[i]--;
            if (hd[3]) begin
               m_codes[i][0] = 3'd7;
               m_codes[i][1] = 3'd0;
               m_codes[i][2] = 3'd7;
               m_codes[i][3] = 3'd0;
               m_codes[i][4] = hd[2:0];
               m_nf[i] = 5;
            end else begin
               m_codes[i][0] = hd[2:0];
               m_nf[i] = 1;
            end
            m_act[i] = 1'b1;
            m_t[i]   = 0;
            m_oc[i]  = m_codes[i][0];
         end
         if (do_push) begin
            m_q[i][m_qn[i]] = {m, c};
            m_qn[i]++;
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
               model_cmp(i);
               if (sd[i] === 1'b1)
                  $display("dut%0d: entry complete, last o_c=%0d at %0t", i, oc[i], $time);
               model_edge(i, rst_s[i], valid[i], code[i], macro[i]);
            end
         end
      end
   end

   task automatic push_seq(input int i, input int nent, input logic [17:0] codes,
                           input logic [5:0] macros, output logic rdy_after);
      int w;
      for (int e = 0; e < nent; e++) begin
         valid[i] = 1'b1;
         code[i]  = codes[3*e +: 3];
         macro[i] = macros[e];
         w = 0;
         while (!ready[i] && w < 2000) begin
            tick(1);
            w++;
         end
         if (w >= 2000)
            timeout("push_wait");
         tick(1);
      end
      valid[i]  = 1'b0;
      rdy_after = ready[i];
   endtask

   task automatic observe(input int i, input int nent, input int totfr, input logic [29:0] exp_oc);
      int p, c, nrise, nfd, nsd, nhigh, first_rise, last_fd, viol, budget;
      logic [2:0] cap[10];
      logic [2:0] oc_c1, prev_oc;
      logic prev_clk, busy_at_fd;
      p = sp[i] + hp[i] + lp[i];
      budget = totfr * p + nent + 50;
      nrise = 0; nfd = 0; nsd = 0; nhigh = 0; viol = 0;
      first_rise = -1; last_fd = -1; c = -1;
      oc_c1 = 3'd0; busy_at_fd = 1'b0;
      prev_clk = oclk[i];
      prev_oc  = oc[i];
      for (int k = 0; k < 10; k++) cap[k] = 3'd0;
      while (nsd < nent && c < budget) begin
         tick(1);
         c++;
         if (c == 1) oc_c1 = oc[i];
         if (oclk[i]) begin
            nhigh++;
            if (oc[i] !== prev_oc) viol++;
            if (!prev_clk) begin
               if (first_rise < 0) first_rise = c;
               if (nrise < 10) cap[nrise] = oc[i];
               nrise++;
            end
         end
         if (fd[i]) begin
            nfd++;
            last_fd = c;
            busy_at_fd = busy[i];
         end
         if (sd[i]) nsd++;
         prev_clk = oclk[i];
         prev_oc  = oc[i];
      end
      if (nsd < nent) timeout("seq_done_wait");
      tick(1);
      chk("frames", nrise, totfr);
      for (int f = 0; f < totfr && f < 10; f++)
         chk($sformatf("frame%0d_code", f), 32'(cap[f]), 32'(exp_oc[3*f +: 3]));
      chk("frame_done_count", nfd, totfr);
      chk("high_cycles", nhigh, totfr * hp[i]);
      chk("first_rise_cycle", first_rise, sp[i] + 1);
      chk("o_c_after_pop", 32'(oc_c1), 32'(exp_oc[2:0]));
      chk("last_frame_done_cycle", last_fd, totfr * p + nent - 1);
      chk("busy_at_last_fd", 32'(busy_at_fd), 1);
      chk("busy_after", 32'(busy[i]), 0);
      chk("o_c_change_while_high", viol, 0);
   endtask

   initial begin
      logic ra;
      int w, nfd;
      sp = '{S0, S1};
      hp = '{H0, H1};
      lp = '{L0, L1};
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 1'b0; m_t[i] = 0; m_nf[i] = 1; m_qn[i] = 0; m_oc[i] = 3'd0;
      end
      vecs[0] = '{0, 1, 18'o1,      6'b000000, 1, 30'o1,      1'b1};
      vecs[1] = '{0, 1, 18'o3,      6'b000001, 5, 30'o30707,  1'b1};
      vecs[2] = '{0, 5, 18'o62105,  6'b000000, 5, 30'o62105,  1'b0};
      vecs[3] = '{0, 6, 18'o654321, 6'b000000, 6, 30'o654321, 1'b0};
      vecs[4] = '{1, 2, 18'o42,     6'b000000, 2, 30'o42,     1'b1};
      vecs[5] = '{1, 1, 18'o7,      6'b000001, 5, 30'o70707,  1'b1};

      rst_s = 2'b11; valid = '0; code = '0; macro = '0;
      tick(2);
      chk_en = 1'b1;
      tick(1);
      rst_s = 2'b00;
      for (int i = 0; i < 2; i++) begin
         chk("reset_o_c", 32'(oc[i]), 0);
         chk("reset_o_clk", 32'(oclk[i]), 0);
         chk("reset_busy", 32'(busy[i]), 0);
         chk("reset_frame_done", 32'(fd[i]), 0);
         chk("reset_seq_done", 32'(sd[i]), 0);
         chk("reset_cmd_ready", 32'(ready[i]), 1);
      end

      for (int v = 0; v < 6; v++) begin
         ra = 1'b0;
         fork
            push_seq(vecs[v].inst, vecs[v].nent, vecs[v].codes, vecs[v].macros, ra);
            observe(vecs[v].inst, vecs[v].nent, vecs[v].totfr, vecs[v].exp_oc);
         join
         chk($sformatf("vec%0d_ready_after_push", v), 32'(ra), 32'(vecs[v].rdy_after));
         tick(2);
      end

      // Reset during HIGH cycle 20 of the first frame with two entries still queued
      push_seq(0, 3, 18'o321, 6'b0, ra);
      w = 0;
      while (!oclk[0] && w < 200) begin
         tick(1);
         w++;
      end
      if (w >= 200) timeout("wait_high");
      tick(19);
      rst_s[0] = 1'b1;
      tick(1);
      rst_s[0] = 1'b0;
      chk("abort_o_clk", 32'(oclk[0]), 0);
      chk("abort_o_c", 32'(oc[0]), 0);
      chk("abort_busy", 32'(busy[0]), 0);
      chk("abort_cmd_ready", 32'(ready[0]), 1);
      nfd = 0;
      for (int k = 0; k < 110; k++) begin
         if (fd[0]) nfd++;
         tick(1);
      end
      chk("abort_no_frame_done", nfd, 0);
      fork
         push_seq(0, 1, 18'o6, 6'b0, ra);
         observe(0, 1, 1, 30'o6);
      join

      // Random traffic on both instances, checked cycle by cycle against the model
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 2; i++) begin
            valid[i] = ($urandom_range(0, 3) == 0);
            code[i]  = 3'($urandom_range(0, 7));
            macro[i] = ($urandom_range(0, 3) == 0);
            rst_s[i] = ($urandom_range(0, 699) == 0);
         end
         tick(1);
      end
      valid = '0;
      rst_s = '0;
      w = 0;
      while (busy != 2'b00 && w < 4000) begin
         tick(1);
         w++;
      end
      if (w >= 4000) timeout("drain");
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
